// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ack data-memory transaction per load/store,
// freezing the upstream pipeline and bubbling MEM/WB while it is outstanding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] WriteDataM,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BubbleW,
  output logic        MisalignM,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic w_access;
  logic w_aligned;
  logic w_idle;
  logic w_issue;

  assign w_access  = MemReadM | MemWriteM;
  assign w_aligned = (AluOutM[1:0] == 2'b00);
  assign w_idle    = (r_state == S_IDLE);
  assign w_issue   = w_idle & w_access & w_aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_state <= S_BUSY;
          r_req   <= 1'b1;
          r_we    <= MemWriteM;
          r_addr  <= AluOutM;
          r_wdata <= WriteDataM;
          r_cnt   <= '0;
        end
        // Ack takes priority over the timeout limit on the same cycle.
        S_BUSY: if (dmem_ack) begin
          r_req   <= 1'b0;
          r_state <= S_DONE;
          if (!r_we) r_rdata <= dmem_rdata;
        end else if (r_cnt == LIMIT) begin
          r_req   <= 1'b0;
          r_err   <= 1'b1;
          r_state <= S_ERR;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign ReadDataM  = r_rdata;
  assign bus_err    = r_err;

  // Stall covers the issue cycle in IDLE; DONE is the single release cycle.
  assign StallM    = ~rst & (w_issue | (r_state == S_BUSY) | (r_state == S_ERR));
  assign MisalignM = ~rst & w_idle & w_access & ~w_aligned;
  assign BubbleW   = StallM | MisalignM;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed test-plan scenarios with literal
// expectations, then random traffic checked every cycle against a transaction model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] AluOutM = '0, WriteDataM = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_req, dmem_we, StallM, BubbleW, MisalignM, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataM;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .AluOutM(AluOutM), .WriteDataM(WriteDataM), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .BubbleW(BubbleW), .MisalignM(MisalignM), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding access, a release cycle, or a
  // sticky error; waits counts BUSY cycles that passed without ack.
  bit          m_on = 0, m_pend = 0, m_done = 0, m_err = 0;
  int          m_waits = 0;
  logic        m_req = 0, m_we = 0, m_berr = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;

  always @(negedge clk) begin
    logic acc, al, idle, e_stall, e_mis;
    acc     = MemReadM | MemWriteM;
    al      = (AluOutM[1:0] == 2'b00);
    idle    = !m_pend && !m_done && !m_err;
    e_stall = !rst && (m_pend || m_err || (idle && acc && al));
    e_mis   = !rst && idle && acc && !al;
    if (m_on) begin
      chk("m_req",    32'(dmem_req),  32'(m_req));
      chk("m_we",     32'(dmem_we),   32'(m_we));
      chk("m_addr",   dmem_addr,      m_addr);
      chk("m_wdata",  dmem_wdata,     m_wdata);
      chk("m_rdata",  ReadDataM,      m_rd);
      chk("m_buserr", 32'(bus_err),   32'(m_berr));
      chk("m_stall",  32'(StallM),    32'(e_stall));
      chk("m_misal",  32'(MisalignM), 32'(e_mis));
      chk("m_bubble", 32'(BubbleW),   32'(e_stall | e_mis));
    end
    if (rst) begin
      m_on = 1; m_pend = 0; m_done = 0; m_err = 0; m_waits = 0;
      m_req = 0; m_we = 0; m_berr = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
    end else if (m_err) begin
      m_err = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_pend) begin
      if (dmem_ack) begin
        m_pend = 0; m_done = 1; m_req = 0;
        if (!m_we) m_rd = dmem_rdata;
      end else if (m_waits + 1 == TO) begin
        m_pend = 0; m_err = 1; m_req = 0; m_berr = 1;
      end else begin
        m_waits++;
      end
    end else if (acc && al) begin
      m_pend = 1; m_waits = 0; m_req = 1;
      m_we = MemWriteM; m_addr = AluOutM; m_wdata = WriteDataM;
    end
  end

  // Runs one access from its IDLE cycle through DONE; ack on the (k+1)th BUSY cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int k,
                        output int nreq, output int nstall, output logic [31:0] rdv);
    int n;
    bit done;
    n = 0; done = 0; nreq = 0; nstall = 0; rdv = '0;
    MemReadM = rd; MemWriteM = wr; AluOutM = a; WriteDataM = wd;
    dmem_rdata = rdat; dmem_ack = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (StallM) nstall++;
      if (dmem_req) nreq++;
      if (!StallM && nstall > 0) begin done = 1; rdv = ReadDataM; end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (done) begin
        MemReadM = 1'b0; MemWriteM = 1'b0;
      end else if (dmem_req) begin
        n++;
        dmem_ack = (n == k + 1);
      end
    end
    if (!done) chk("access_done", 32'(0), 32'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    32'(dmem_req),  32'(0));
    chk({tag, "_we"},     32'(dmem_we),   32'(0));
    chk({tag, "_addr"},   dmem_addr,      32'(0));
    chk({tag, "_wdata"},  dmem_wdata,     32'(0));
    chk({tag, "_rdata"},  ReadDataM,      32'(0));
    chk({tag, "_stall"},  32'(StallM),    32'(0));
    chk({tag, "_bubble"}, 32'(BubbleW),   32'(0));
    chk({tag, "_misal"},  32'(MisalignM), 32'(0));
    chk({tag, "_buserr"}, 32'(bus_err),   32'(0));
  endtask

  initial begin
    int nr, ns;
    logic [31:0] rdv;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    // Load, zero waits
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, nr, ns, rdv);
    chk("ld_req_cycles", 32'(nr), 32'(1));
    chk("ld_stall_cycles", 32'(ns), 32'(2));
    chk("ld_rdata_done", rdv, 32'hDEADBEEF);

    // Store, three waits (ack on the limit cycle of TO=4)
    access(1'b0, 1'b1, 32'h204, 32'h12345678, 32'h0BADF00D, 3, nr, ns, rdv);
    chk("st_req_cycles", 32'(nr), 32'(4));
    chk("st_stall_cycles", 32'(ns), 32'(5));
    chk("st_we", 32'(dmem_we), 32'(1));
    chk("st_addr", dmem_addr, 32'h204);
    chk("st_wdata", dmem_wdata, 32'h12345678);
    chk("st_rdata_kept", ReadDataM, 32'hDEADBEEF);
    chk("st_no_err", 32'(bus_err), 32'(0));

    // Read and write together behaves as a write
    access(1'b1, 1'b1, 32'h208, 32'hAAAA5555, 32'h11111111, 1, nr, ns, rdv);
    chk("rw_we", 32'(dmem_we), 32'(1));
    chk("rw_rdata_kept", ReadDataM, 32'hDEADBEEF);

    // Misaligned load
    MemReadM = 1'b1; AluOutM = 32'h102;
    @(negedge clk);
    chk("mis_pulse", 32'(MisalignM), 32'(1));
    chk("mis_stall", 32'(StallM), 32'(0));
    chk("mis_bubble", 32'(BubbleW), 32'(1));
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'(0));
    chk("mis_pulse_end", 32'(MisalignM), 32'(0));
    @(posedge clk); #1;

    // Back-to-back load then store, plus a stray ack in IDLE
    access(1'b1, 1'b0, 32'h110, 32'h0, 32'h01020304, 0, nr, ns, rdv);
    chk("b2b_ld_req", 32'(nr), 32'(1));
    chk("b2b_ld_stall", 32'(ns), 32'(2));
    access(1'b0, 1'b1, 32'h114, 32'h55667788, 32'hFFFFFFFF, 0, nr, ns, rdv);
    chk("b2b_st_req", 32'(nr), 32'(1));
    chk("b2b_st_addr", dmem_addr, 32'h114);
    chk("b2b_rdata", ReadDataM, 32'h01020304);
    dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
    @(negedge clk);
    chk("stray_req", 32'(dmem_req), 32'(0));
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_rdata", ReadDataM, 32'h01020304);
    chk("stray_stall", 32'(StallM), 32'(0));
    @(posedge clk); #1;

    // Timeout with no ack
    MemReadM = 1'b1; AluOutM = 32'h300; nr = 0; ns = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dmem_req) nr++;
      if (StallM) ns++;
      @(posedge clk); #1;
    end
    chk("to_req_cycles", 32'(nr), 32'(4));
    chk("to_stall_cycles", 32'(ns), 32'(10));
    chk("to_buserr", 32'(bus_err), 32'(1));
    rst = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("to_reset");
    @(posedge clk); #1;

    // Ack on the fourth BUSY cycle beats the timeout
    access(1'b1, 1'b0, 32'h304, 32'h0, 32'h77778888, 3, nr, ns, rdv);
    chk("lim_req_cycles", 32'(nr), 32'(4));
    chk("lim_rdata", rdv, 32'h77778888);
    chk("lim_no_err", 32'(bus_err), 32'(0));

    // Reset during BUSY, late ack ignored
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    MemReadM = 1'b1; AluOutM = 32'h400; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rb_req", 32'(dmem_req), 32'(0));
    chk("rb_stall", 32'(StallM), 32'(0));
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rb_rdata", ReadDataM, 32'h0);
    chk("rb_req_late", 32'(dmem_req), 32'(0));
    @(posedge clk); #1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 79) == 0) || (bus_err && $urandom_range(0, 3) == 0);
      MemReadM   = ($urandom_range(0, 2) == 0);
      MemWriteM  = ($urandom_range(0, 3) == 0);
      AluOutM    = $urandom;
      if ($urandom_range(0, 3) != 0) AluOutM[1:0] = 2'b00;
      WriteDataM = $urandom;
      dmem_rdata = $urandom;
      dmem_ack   = dmem_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end

    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
